// File: rtl/sevseg_scan_n.sv
// Multiplexed N-digit seven-segment scanner with per-frame snapshot, PWM dimming and leading-zero blanking.
// One-cycle registered output latency; no backpressure, inputs are sampled once per frame.
module sevseg_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_LOG2  = 16,
  parameter int BRIGHT_W   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic                    i_lz_blank,
  input  logic [BRIGHT_W-1:0]     i_bright,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    lz;
  } snap_t;

  logic [SCAN_LOG2-1:0] r_tick;
  logic [IDX_W-1:0]     r_idx;
  snap_t                r_snap;
  logic                 r_wrap;
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                 r_frame_start;

  logic                  w_tick_max;
  logic                  w_frame_end;
  logic [3:0]            w_nib;
  logic                  w_dp_req;
  logic                  w_blank;
  logic                  w_zero_run;
  logic [BRIGHT_W-1:0]   w_phase;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign w_tick_max  = &r_tick;
  assign w_frame_end = w_tick_max && (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else begin
      r_tick <= r_tick + SCAN_LOG2'(1);
      if (w_tick_max) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Captured on the last cycle of the last slot so a whole frame decodes one consistent value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snap <= '0;
    end else if (w_frame_end) begin
      r_snap.digits <= i_digits;
      r_snap.dp     <= i_dp_in;
      r_snap.lz     <= i_lz_blank;
    end
  end

  // Walk from the most significant digit down so the zero run is known when reaching the current slot.
  always_comb begin
    w_nib      = '0;
    w_dp_req   = 1'b0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_snap.digits[4*k +: 4] == 4'h0);
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_snap.digits[4*k +: 4];
        w_dp_req = r_snap.dp[k];
        w_blank  = r_snap.lz && (k != 0) && w_zero_run;
      end
    end
  end

  assign w_phase = r_tick[SCAN_LOG2-1 -: BRIGHT_W];
  assign w_lit   = (&i_bright) || (w_phase < i_bright);

  always_comb begin
    w_an = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_lit && (r_idx == IDX_W'(k))) begin
        w_an[k] = 1'b0;
      end
    end
  end

  // frame_start is delayed by r_wrap so it lines up with the first registered output of digit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_an          <= '1;
      r_wrap        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_blank ? 7'h7F : glyph(w_nib);
      r_dp          <= ~w_dp_req;
      r_an          <= w_an;
      r_wrap        <= w_frame_end;
      r_frame_start <= r_wrap;
    end
  end

  assign o_seg         = r_seg;
  assign o_dp          = r_dp;
  assign o_an          = r_an;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_sevseg_scan_n.sv
// Bench for sevseg_scan_n: 4-digit and 6-digit instances against a cycle-count arithmetic reference model.
module tb_sevseg_scan_n;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits4;
  logic [3:0]  dpin4;
  logic [23:0] digits6;
  logic [5:0]  dpin6;
  logic        lz;
  logic [1:0]  bright;

  logic [6:0]  seg4, seg6;
  logic        dpo4, dpo6;
  logic [3:0]  an4;
  logic [5:0]  an6;
  logic        fs4, fs6;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sevseg_scan_n #(.NUM_DIGITS(4), .SCAN_LOG2(4), .BRIGHT_W(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_digits(digits4), .i_dp_in(dpin4),
    .i_lz_blank(lz), .i_bright(bright), .o_seg(seg4), .o_dp(dpo4),
    .o_an(an4), .o_frame_start(fs4));

  sevseg_scan_n #(.NUM_DIGITS(6), .SCAN_LOG2(4), .BRIGHT_W(2)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_digits(digits6), .i_dp_in(dpin6),
    .i_lz_blank(lz), .i_bright(bright), .o_seg(seg6), .o_dp(dpo6),
    .o_an(an6), .o_frame_start(fs6));

  logic [12:0] obs4, exp4;
  logic [14:0] obs6, exp6;
  assign obs4 = {fs4, seg4, dpo4, an4};
  assign obs6 = {fs6, seg6, dpo6, an6};
  localparam logic [12:0] RST4 = {1'b0, 7'h7F, 1'b1, 4'hF};
  localparam logic [14:0] RST6 = {1'b0, 7'h7F, 1'b1, 6'h3F};

  logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] F1  [4] = '{7'h0E, 7'h24, 7'h08, 7'h79};
  logic [6:0] LZ1 [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
  logic [6:0] LZ2 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};

  // Output for scan position c (cycles since reset): slot = c/16, phase = top two tick bits.
  function automatic logic [16:0] model_out(int c, int n, logic [31:0] sd, logic [7:0] sdp,
                                            logic slz, logic [1:0] br);
    int t, i;
    logic [7:0] an;
    logic [3:0] nib;
    logic blank, en, fs;
    t   = c % T;
    i   = (c / T) % n;
    en  = (br == 2'd3) || ((t / 4) < int'(br));
    an  = 8'hFF;
    if (en) an[i] = 1'b0;
    nib   = 4'(sd >> (4 * i));
    blank = slz && (i > 0) && ((sd >> (4 * i)) == 32'h0);
    fs    = (c > 0) && (c % (n * T) == 0);
    return {fs, blank ? 7'h7F : GLYPH[nib], ~sdp[i], an};
  endfunction

  int c4 = 0, c6 = 0;
  logic [31:0] sd4 = '0, sd6 = '0;
  logic [7:0]  sdp4 = '0, sdp6 = '0;
  logic        slz4 = 1'b0, slz6 = 1'b0;
  logic [16:0] r4, r6;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c4 = 0; sd4 = '0; sdp4 = '0; slz4 = 1'b0; exp4 = RST4;
      c6 = 0; sd6 = '0; sdp6 = '0; slz6 = 1'b0; exp6 = RST6;
    end else begin
      r4 = model_out(c4, 4, sd4, sdp4, slz4, bright);
      r6 = model_out(c6, 6, sd6, sdp6, slz6, bright);
      exp4 = {r4[16:8], r4[3:0]};
      exp6 = {r6[16:8], r6[5:0]};
      if (c4 % 64 == 63) begin sd4 = {16'h0, digits4}; sdp4 = {4'h0, dpin4}; slz4 = lz; end
      if (c6 % 96 == 95) begin sd6 = {8'h0, digits6}; sdp6 = {2'b0, dpin6}; slz6 = lz; end
      c4++;
      c6++;
    end
  end

  task automatic to_frame_start();
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ((c4 - 1) % 64 == 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; digits4 = 16'h1A2F; dpin4 = 4'h0; digits6 = 24'h90_3C07;
    dpin6 = 6'h00; lz = 1'b0; bright = 2'd3;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs4 !== RST4) begin miscompares++; $display("FAIL reset4 got %h want %h", obs4, RST4); end
    vectors++;
    if (obs6 !== RST6) begin miscompares++; $display("FAIL reset6 got %h want %h", obs6, RST6); end
  endtask

  task automatic test_first_frames();
    int c, k;
    logic [3:0] want_an;
    logic [6:0] want_seg;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      c = c4 - 1;
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL first4 c=%0d got %h want %h", c, obs4, exp4); end
      vectors++;
      if (obs6 !== exp6) begin miscompares++; $display("FAIL first6 c=%0d got %h want %h", c, obs6, exp6); end
      if (c % 16 == 8) begin
        k = (c / 16) % 4;
        want_seg = (c < 64) ? 7'h40 : F1[k];
        want_an  = ~(4'b0001 << k);
        vectors++;
        if (seg4 !== want_seg || an4 !== want_an)
          begin miscompares++; $display("FAIL slot_glyph c=%0d seg %h an %b want %h %b", c, seg4, an4, want_seg, want_an); end
      end
      if (c == 0 || c == 64) begin
        vectors++;
        if (fs4 !== (c == 64)) begin miscompares++; $display("FAIL fs_edge c=%0d got %b", c, fs4); end
      end
    end
  endtask

  task automatic test_midframe_change();
    int c, k, fs_cnt;
    logic [6:0] want_seg;
    fs_cnt = 0;
    for (int j = 0; j < 192; j++) begin
      @(negedge clk);
      c = c4 - 1;
      if (c == 150) digits4 = 16'h0000;
      if (fs4 === 1'b1) fs_cnt++;
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL mid4 c=%0d got %h want %h", c, obs4, exp4); end
      if (c % 16 == 8) begin
        k = (c / 16) % 4;
        want_seg = (c / 64 == 2) ? F1[k] : 7'h40;
        vectors++;
        if (seg4 !== want_seg) begin miscompares++; $display("FAIL mid_glyph c=%0d got %h want %h", c, seg4, want_seg); end
      end
    end
    vectors++;
    if (fs_cnt != 3) begin miscompares++; $display("FAIL fs_count got %0d want 3", fs_cnt); end
  endtask

  task automatic test_lz_blank();
    int o, k;
    to_frame_start();
    lz = 1'b1; digits4 = 16'h0050; dpin4 = 4'b0000;
    repeat (64) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL lz_pre c=%0d got %h want %h", c4 - 1, obs4, exp4); end
    end
    digits4 = 16'h0000; dpin4 = 4'b1000;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < 64; j++) begin
        @(negedge clk);
        o = (c4 - 1) % 64;
        vectors++;
        if (obs4 !== exp4) begin miscompares++; $display("FAIL lz4 c=%0d got %h want %h", c4 - 1, obs4, exp4); end
        if (o % 16 == 8) begin
          k = o / 16;
          vectors++;
          if (pass == 0 && (seg4 !== LZ1[k] || dpo4 !== 1'b1))
            begin miscompares++; $display("FAIL lz_0050 k=%0d seg %h dp %b want %h 1", k, seg4, dpo4, LZ1[k]); end
          if (pass == 1 && (seg4 !== LZ2[k] || dpo4 !== (k != 3)))
            begin miscompares++; $display("FAIL lz_0000 k=%0d seg %h dp %b want %h %b", k, seg4, dpo4, LZ2[k], k != 3); end
        end
      end
    end
    lz = 1'b0;
  endtask

  task automatic test_pwm();
    logic [1:0] levels [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
    int lit, want;
    digits4 = 16'($urandom);
    foreach (levels[i]) begin
      to_frame_start();
      bright = levels[i];
      lit = 0;
      repeat (64) begin
        @(negedge clk);
        if (an4 !== 4'hF) lit++;
        vectors++;
        if (obs4 !== exp4 || $countones(~an4) > 1)
          begin miscompares++; $display("FAIL pwm4 b=%0d got %h want %h", levels[i], obs4, exp4); end
      end
      want = (levels[i] == 2'd3) ? 64 : 16 * int'(levels[i]);
      vectors++;
      if (lit != want) begin miscompares++; $display("FAIL pwm_duty b=%0d got %0d want %0d", levels[i], lit, want); end
    end
    repeat (200) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL pwm_live c=%0d got %h want %h", c4 - 1, obs4, exp4); end
      if ($urandom_range(0, 3) == 0) bright = 2'($urandom);
    end
    bright = 2'd3;
  endtask

  task automatic test_six_digits();
    int last, pulses;
    last = -1; pulses = 0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if ((c6 - 1) % 96 == 0) begin
        digits6 = 24'($urandom); dpin6 = 6'($urandom); lz = 1'($urandom);
        if ($urandom_range(0, 1) == 0) digits6[23:12] = 12'h000;
      end
      vectors++;
      if (obs6 !== exp6 || $countones(~an6) > 1)
        begin miscompares++; $display("FAIL six c=%0d got %h want %h", c6 - 1, obs6, exp6); end
      if (fs6 === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (j - last != 96) begin miscompares++; $display("FAIL six_period got %0d want 96", j - last); end
        end
        last = j;
        pulses++;
      end
    end
    vectors++;
    if (pulses < 4) begin miscompares++; $display("FAIL six_pulses got %0d want >=4", pulses); end
    lz = 1'b0;
  endtask

  task automatic test_random();
    repeat (1500) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL rand4 c=%0d got %h want %h", c4 - 1, obs4, exp4); end
      vectors++;
      if (obs6 !== exp6) begin miscompares++; $display("FAIL rand6 c=%0d got %h want %h", c6 - 1, obs6, exp6); end
      case ($urandom_range(0, 11))
        0: digits4 = 16'($urandom);
        1: digits4 = 16'($urandom_range(0, 255));
        2: digits6 = 24'($urandom);
        3: dpin4   = 4'($urandom);
        4: dpin6   = 6'($urandom);
        5: lz      = 1'($urandom);
        6: bright  = 2'($urandom);
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset();
    bright = 2'd3; lz = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if ((c4 - 1) % 16 == 5) break;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs4 !== RST4) begin miscompares++; $display("FAIL async4 got %h want %h", obs4, RST4); end
    vectors++;
    if (obs6 !== RST6) begin miscompares++; $display("FAIL async6 got %h want %h", obs6, RST6); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (seg4 !== 7'h40 || an4 !== 4'b1110 || dpo4 !== 1'b1 || fs4 !== 1'b0)
      begin miscompares++; $display("FAIL restart got seg %h an %b dp %b fs %b want 40 1110 1 0", seg4, an4, dpo4, fs4); end
    repeat (130) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL post4 c=%0d got %h want %h", c4 - 1, obs4, exp4); end
      vectors++;
      if (obs6 !== exp6) begin miscompares++; $display("FAIL post6 c=%0d got %h want %h", c6 - 1, obs6, exp6); end
    end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_midframe_change();
    test_lz_blank();
    test_pwm();
    test_six_digits();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
